mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM for the 32-bit MIPS datapath (ALU32bit, alu_control_unit, register file, memory).
//  Sequences each instruction through fetch/decode/execute/memory/writeback and drives all datapath controls.
//  Handshakes with a shared instruction/data memory through mem_ready; a watchdog traps stalled accesses.
//  Supports R-type, LW, SW, BEQ, ADDI; J is optional. PC is word-addressed: increment by 1.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive cycles waiting on mem_ready before trapping (>=1)
//  CNT_W        5   watchdog counter width; must hold MEM_TIMEOUT
// PORTS
//  clock        in   1  single clock, all state updates on posedge
//  reset_n      in   1  asynchronous, active-low reset
//  opcode       in   6  instruction[31:26] from the IR
//  alu_zero     in   1  ALU zero flag (rs == rt for BEQ)
//  mem_ready    in   1  memory access complete this cycle
//  PCWrite      out  1  unconditional PC load
//  PCWriteCond  out  1  PC load if alu_zero
//  PCSource     out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
//  IorD         out  1  memory address: 0 PC, 1 ALUOut
//  MemRead      out  1  memory read request
//  MemWrite     out  1  memory write request
//  IRWrite      out  1  latch instruction register
//  RegDst       out  1  1 rd, 0 rt
//  RegWrite     out  1  register-file write strobe
//  MemToReg     out  1  1 MDR, 0 ALUOut
//  ALUSrcA      out  1  0 PC, 1 rs_content
//  ALUSrcB      out  2  00 rt, 01 const 1, 10 sign-ext imm, 11 sign-ext imm (branch offset)
//  ALUop        out  2  00 add, 01 sub, 10 funct-decoded (to alu_control_unit)
//  branch_taken out  1  PCWriteCond & alu_zero
//  trap         out  1  sticky error: illegal opcode or memory timeout
//  state        out  4  current state encoding (debug)
// BEHAVIOUR
//  - Reset (reset_n=0): state=FETCH(0), watchdog=0, trap=0; all control outputs 0 while in reset.
//  - Outputs are Moore decodes of state; PCWrite/IRWrite in FETCH and RegWrite in MEMWB are gated by mem_ready.
//  - States: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8,
//    ADDIEX 9, ADDIWB 10, JUMP 11, TRAP 15.
//  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00; hold until mem_ready;
//    on mem_ready: IRWrite=1, PCWrite=1 (PC<=PC+1), go DECODE.
//  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00 (ALUOut<=PC+imm). Dispatch: 000000->EXEC, 100011/101011->MEMADR,
//    000100->BRANCH, 001000->ADDIEX, 000010->JUMP (JUMP_EN only), else->TRAP.
//  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=00; LW->MEMRD, SW->MEMWR.
//  - MEMRD: MemRead=1, IorD=1; on mem_ready -> MEMWB. MEMWB: RegDst=0, MemToReg=1, RegWrite=1 -> FETCH.
//  - MEMWR: MemWrite=1, IorD=1; on mem_ready -> FETCH.
//  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=10 -> RWB. RWB: RegDst=1, MemToReg=0, RegWrite=1 -> FETCH.
//  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01 -> FETCH; PC<=PC+1+imm iff alu_zero.
//  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUop=00 -> ADDIWB. ADDIWB: RegDst=0, MemToReg=0, RegWrite=1 -> FETCH.
//  - Watchdog: in FETCH/MEMRD/MEMWR with mem_ready=0 counter increments; cleared on mem_ready or state exit.
//    Counter reaching MEM_TIMEOUT while mem_ready still 0 -> TRAP. mem_ready on that same cycle wins (no trap).
//  - TRAP: all controls 0, trap=1; absorbing until reset_n asserted.
//  - Reset mid-access: FSM returns to FETCH immediately; no write strobe may glitch high.
//  - Every instruction issues exactly one register or memory write (none for BEQ/J); no strobe lasts >1 cycle.
// CONFIGURATION
//  MIPS_JUMP_EN defined: opcode 000010 -> JUMP: PCSource=10, PCWrite=1 for one cycle (PC<={PC[31:26],addr}) -> FETCH.
//  MIPS_JUMP_EN undefined: JUMP state unreachable; opcode 000010 -> TRAP like any illegal opcode.
// TESTING
//  1 reset_n=0 mid-MEMRD -> state=0, all outputs 0; release, mem_ready=1 -> FETCH->DECODE in 1 cycle, IRWrite pulse.
//  2 BEQ, alu_zero=1, imm=3, PC=4 -> state seq 0,1,8,0; branch_taken=1; next fetch at PC=8. alu_zero=0 -> PC=5.
//  3 LW with mem_ready delayed 3 cycles in MEMRD -> MemRead held 4 cycles, single RegWrite in MEMWB, MemToReg=1.
//  4 SW, mem_ready held 0 -> trap=1 after MEM_TIMEOUT=16 wait cycles, no further strobes until reset.
//  5 opcode 111111 -> DECODE->TRAP; opcode 000010 -> JUMP with MIPS_JUMP_EN, TRAP without.
//  6 R-type then ADDI back-to-back -> RegDst=1 then 0; each RegWrite exactly one cycle; 4 cycles each (mem_ready=1).

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module  : mips_multicycle_ctrl                                           |
// | Brief   : Multi-cycle MIPS control FSM with memory-stall watchdog/trap.  |
// |           Optional J support enabled by defining MIPS_JUMP_EN.           |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       MemToReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic       branch_taken,
  output logic       trap,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
`ifdef MIPS_JUMP_EN
  localparam logic [5:0] c_OP_J     = 6'b000010;
`endif
  localparam logic [CNT_W-1:0] c_WDOG_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

  // Moore part of the controls; is_fetch/is_memwb are later qualified by mem_ready.
  typedef struct packed {
    logic       pc_write_jmp;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       reg_write_alu;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       is_fetch;
    logic       is_memwb;
    logic       trap;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.is_fetch  = 1'b1;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.is_memwb   = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_RWB: begin
        c.reg_dst       = 1'b1;
        c.reg_write_alu = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ADDIWB: c.reg_write_alu = 1'b1;
      S_JUMP: begin
        c.pc_write_jmp = 1'b1;
        c.pc_source    = 2'b10;
      end
      S_TRAP:   c.trap = 1'b1;
      default:  c.trap = 1'b1;
    endcase
    return c;
  endfunction

  state_t           r_state;
  state_t           w_next;
  ctrl_t            r_ctrl;
  logic [CNT_W-1:0] r_wdog;
  logic             w_wait;
  logic             w_timeout;

  assign w_wait    = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_timeout = w_wait && !mem_ready && (r_wdog == c_WDOG_LIMIT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          c_OP_RTYPE:       w_next = S_EXEC;
          c_OP_LW, c_OP_SW: w_next = S_MEMADR;
          c_OP_BEQ:         w_next = S_BRANCH;
          c_OP_ADDI:        w_next = S_ADDIEX;
`ifdef MIPS_JUMP_EN
          c_OP_J:           w_next = S_JUMP;
`endif
          default:          w_next = S_TRAP;
        endcase
      end
      S_MEMADR: w_next = (opcode == c_OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  if (mem_ready) w_next = S_FETCH;
      S_EXEC:   w_next = S_RWB;
      S_RWB:    w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_ADDIEX: w_next = S_ADDIWB;
      S_ADDIWB: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_TRAP;
    endcase
    // A stalled access traps only while mem_ready is still low, so a late ready wins.
    if (w_timeout) w_next = S_TRAP;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
      r_wdog  <= '0;
      r_ctrl  <= decode_ctrl(S_FETCH);
    end else begin
      r_state <= w_next;
      r_wdog  <= (w_wait && !mem_ready && (w_next == r_state)) ? r_wdog + CNT_W'(1) : '0;
      r_ctrl  <= decode_ctrl(w_next);
    end
  end

  // Masking with reset_n keeps every strobe low for the whole reset window.
  assign PCWrite      = reset_n & (r_ctrl.pc_write_jmp | (r_ctrl.is_fetch & mem_ready));
  assign PCWriteCond  = reset_n & r_ctrl.pc_write_cond;
  assign PCSource     = {2{reset_n}} & r_ctrl.pc_source;
  assign IorD         = reset_n & r_ctrl.iord;
  assign MemRead      = reset_n & r_ctrl.mem_read;
  assign MemWrite     = reset_n & r_ctrl.mem_write;
  assign IRWrite      = reset_n & r_ctrl.is_fetch & mem_ready;
  assign RegDst       = reset_n & r_ctrl.reg_dst;
  assign RegWrite     = reset_n & (r_ctrl.reg_write_alu | (r_ctrl.is_memwb & mem_ready));
  assign MemToReg     = reset_n & r_ctrl.mem_to_reg;
  assign ALUSrcA      = reset_n & r_ctrl.alu_src_a;
  assign ALUSrcB      = {2{reset_n}} & r_ctrl.alu_src_b;
  assign ALUop        = {2{reset_n}} & r_ctrl.alu_op;
  assign branch_taken = PCWriteCond & alu_zero;
  assign trap         = reset_n & r_ctrl.trap;
  assign state        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module  : tb_mips_multicycle_ctrl                                        |
// | Brief   : Directed self-checking bench with a tiny PC/ALUOut model.      |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mips_multicycle_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic       alu_zero;
  logic       mem_ready;
  wire        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  wire        RegDst, RegWrite, MemToReg, ALUSrcA, branch_taken, trap;
  wire  [1:0] PCSource, ALUSrcB, ALUop;
  wire  [3:0] state;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCSource(PCSource), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
    .branch_taken(branch_taken), .trap(trap), .state(state)
  );

  always #5 clock = ~clock;

  wire [17:0] all_ctrl = {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
                          RegDst, RegWrite, MemToReg, ALUSrcA, ALUSrcB, ALUop, branch_taken, trap};

  int vectors = 0;
  int miscompares = 0;

  // Datapath model: PC, ALUOut and a count of register/memory write strobes.
  logic        pc_load = 1'b0;
  logic [31:0] pc_init = '0;
  logic [31:0] imm = '0;
  logic [25:0] jaddr = '0;
  logic [31:0] r_pc = '0;
  logic [31:0] r_aluout = '0;
  int          r_wr_count = 0;
  logic [31:0] w_alu_a, w_alu_b, w_alu_res;

  always_comb begin
    w_alu_a   = ALUSrcA ? 32'd0 : r_pc;
    w_alu_b   = (ALUSrcB == 2'b00) ? 32'd0 : (ALUSrcB == 2'b01) ? 32'd1 : imm;
    w_alu_res = (ALUop == 2'b01) ? (w_alu_a - w_alu_b) : (w_alu_a + w_alu_b);
  end

  always @(posedge clock) begin
    if (pc_load) r_pc <= pc_init;
    else if (PCWrite || (PCWriteCond && alu_zero)) begin
      case (PCSource)
        2'b00:   r_pc <= w_alu_res;
        2'b01:   r_pc <= r_aluout;
        default: r_pc <= {r_pc[31:26], jaddr};
      endcase
    end
    r_aluout <= w_alu_res;
    if (RegWrite || MemWrite) r_wr_count <= r_wr_count + 1;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] pinit);
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    alu_zero  = 1'b0;
    pc_load   = 1'b1;
    pc_init   = pinit;
    tick();
    pc_load = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0; opcode = 6'b100011;
    tick();
    vectors++;
    if ({state, all_ctrl} !== {4'd0, 18'h0}) begin
      miscompares++; $display("FAIL reset_state: got %b expected %b", {state, all_ctrl}, {4'd0, 18'h0});
    end
    reset_n = 1'b1; mem_ready = 1'b1;
    tick(); tick();
    vectors++;
    if ({state, ALUSrcA, ALUSrcB} !== {4'd2, 1'b1, 2'b10}) begin
      miscompares++; $display("FAIL reset_memadr: got %b expected %b", {state, ALUSrcA, ALUSrcB}, {4'd2, 3'b110});
    end
    tick(); mem_ready = 1'b0; tick(); tick();
    vectors++;
    if ({state, MemRead, IorD} !== {4'd3, 2'b11}) begin
      miscompares++; $display("FAIL reset_memrd: got %b expected %b", {state, MemRead, IorD}, {4'd3, 2'b11});
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({state, all_ctrl} !== {4'd0, 18'h0}) begin
      miscompares++; $display("FAIL reset_mid_memrd: got %b expected %b", {state, all_ctrl}, {4'd0, 18'h0});
    end
    tick();
    reset_n = 1'b1; mem_ready = 1'b1;
    #1;
    vectors++;
    if ({state, IRWrite, PCWrite, MemRead} !== {4'd0, 3'b111}) begin
      miscompares++; $display("FAIL reset_release_fetch: got %b expected %b", {state, IRWrite, PCWrite, MemRead}, {4'd0, 3'b111});
    end
    tick();
    vectors++;
    if ({state, IRWrite} !== {4'd1, 1'b0}) begin
      miscompares++; $display("FAIL reset_release_decode: got %b expected %b", {state, IRWrite}, {4'd1, 1'b0});
    end
  endtask

  task automatic test_beq(input logic zero, input logic [31:0] exp_pc);
    int w0;
    do_reset(32'd4);
    w0 = r_wr_count;
    opcode = 6'b000100; imm = 32'd3; alu_zero = zero; mem_ready = 1'b1;
    tick();
    vectors++;
    if ({state, ALUSrcA, ALUSrcB, ALUop} !== {4'd1, 1'b0, 2'b11, 2'b00}) begin
      miscompares++; $display("FAIL beq_decode: got %b expected %b", {state, ALUSrcA, ALUSrcB, ALUop}, {4'd1, 5'b01100});
    end
    tick();
    vectors++;
    if ({state, PCWriteCond, PCSource, ALUop, branch_taken} !== {4'd8, 1'b1, 2'b01, 2'b01, zero}) begin
      miscompares++; $display("FAIL beq_branch z=%0d: got %b expected %b", zero,
        {state, PCWriteCond, PCSource, ALUop, branch_taken}, {4'd8, 5'b10101, zero});
    end
    tick();
    vectors++;
    if ({state, r_pc} !== {4'd0, exp_pc}) begin
      miscompares++; $display("FAIL beq_next_pc z=%0d: got state=%0d pc=%0d expected state=0 pc=%0d", zero, state, r_pc, exp_pc);
    end
    vectors++;
    if (r_wr_count !== w0) begin
      miscompares++; $display("FAIL beq_no_write: got %0d writes expected 0", r_wr_count - w0);
    end
  endtask

  task automatic test_lw_wait;
    int w0;
    do_reset(32'd0);
    w0 = r_wr_count;
    opcode = 6'b100011; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({state, MemRead, IorD, RegWrite} !== {4'd3, 3'b110}) begin
        miscompares++; $display("FAIL lw_wait_%0d: got %b expected %b", i, {state, MemRead, IorD, RegWrite}, {4'd3, 3'b110});
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    vectors++;
    if ({state, MemRead, RegWrite} !== {4'd3, 2'b10}) begin
      miscompares++; $display("FAIL lw_ready: got %b expected %b", {state, MemRead, RegWrite}, {4'd3, 2'b10});
    end
    tick();
    vectors++;
    if ({state, RegWrite, MemToReg, RegDst, MemRead} !== {4'd4, 4'b1100}) begin
      miscompares++; $display("FAIL lw_memwb: got %b expected %b", {state, RegWrite, MemToReg, RegDst, MemRead}, {4'd4, 4'b1100});
    end
    tick();
    vectors++;
    if ({state, RegWrite} !== {4'd0, 1'b0} || r_wr_count !== w0 + 1) begin
      miscompares++; $display("FAIL lw_done: got state=%0d writes=%0d expected state=0 writes=1", state, r_wr_count - w0);
    end
  endtask

  task automatic test_sw_timeout(input logic rescue);
    int w0;
    do_reset(32'd0);
    opcode = 6'b101011; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1;
    vectors++;
    if ({state, MemWrite, IorD} !== {4'd5, 2'b11}) begin
      miscompares++; $display("FAIL sw_memwr: got %b expected %b", {state, MemWrite, IorD}, {4'd5, 2'b11});
    end
    repeat (15) tick();
    vectors++;
    if ({state, trap} !== {4'd5, 1'b0}) begin
      miscompares++; $display("FAIL sw_wait15 r=%0d: got %b expected %b", rescue, {state, trap}, {4'd5, 1'b0});
    end
    if (rescue) begin
      mem_ready = 1'b1;
      tick();
      vectors++;
      if ({state, trap} !== {4'd0, 1'b0}) begin
        miscompares++; $display("FAIL sw_late_ready: got %b expected %b", {state, trap}, {4'd0, 1'b0});
      end
    end else begin
      tick();
      vectors++;
      if ({state, all_ctrl} !== {4'd15, 18'h1}) begin
        miscompares++; $display("FAIL sw_timeout_trap: got %b expected %b", {state, all_ctrl}, {4'd15, 18'h1});
      end
      w0 = r_wr_count;
      mem_ready = 1'b1; opcode = 6'b100011;
      repeat (4) tick();
      vectors++;
      if ({state, all_ctrl} !== {4'd15, 18'h1} || r_wr_count !== w0) begin
        miscompares++; $display("FAIL sw_trap_absorb: got state=%0d ctrl=%b writes=%0d expected state=15 ctrl=%b writes=0",
          state, all_ctrl, r_wr_count - w0, 18'h1);
      end
      do_reset(32'd0);
      #1;
      vectors++;
      if ({state, trap} !== {4'd0, 1'b0}) begin
        miscompares++; $display("FAIL sw_trap_cleared: got %b expected %b", {state, trap}, {4'd0, 1'b0});
      end
    end
  endtask

  task automatic test_opcode;
    do_reset(32'd0);
    opcode = 6'b111111; mem_ready = 1'b1;
    tick(); tick();
    vectors++;
    if ({state, trap, RegWrite, MemWrite} !== {4'd15, 3'b100}) begin
      miscompares++; $display("FAIL illegal_op: got %b expected %b", {state, trap, RegWrite, MemWrite}, {4'd15, 3'b100});
    end
    do_reset(32'd0);
    opcode = 6'b000010; jaddr = 26'h0000123; mem_ready = 1'b1;
    tick(); tick();
`ifdef MIPS_JUMP_EN
    vectors++;
    if ({state, PCWrite, PCSource} !== {4'd11, 1'b1, 2'b10}) begin
      miscompares++; $display("FAIL jump_state: got %b expected %b", {state, PCWrite, PCSource}, {4'd11, 3'b110});
    end
    tick();
    vectors++;
    if ({state, r_pc} !== {4'd0, 32'h123}) begin
      miscompares++; $display("FAIL jump_pc: got state=%0d pc=%0h expected state=0 pc=123", state, r_pc);
    end
`else
    vectors++;
    if ({state, trap} !== {4'd15, 1'b1}) begin
      miscompares++; $display("FAIL jump_disabled: got %b expected %b", {state, trap}, {4'd15, 1'b1});
    end
`endif
  endtask

  task automatic test_back_to_back;
    int w0;
    do_reset(32'd0);
    w0 = r_wr_count;
    opcode = 6'b000000; mem_ready = 1'b1;
    tick(); tick();
    vectors++;
    if ({state, ALUSrcA, ALUSrcB, ALUop, RegWrite} !== {4'd6, 1'b1, 2'b00, 2'b10, 1'b0}) begin
      miscompares++; $display("FAIL rtype_exec: got %b expected %b", {state, ALUSrcA, ALUSrcB, ALUop, RegWrite}, {4'd6, 6'b100100});
    end
    tick();
    vectors++;
    if ({state, RegDst, RegWrite, MemToReg} !== {4'd7, 3'b110}) begin
      miscompares++; $display("FAIL rtype_rwb: got %b expected %b", {state, RegDst, RegWrite, MemToReg}, {4'd7, 3'b110});
    end
    tick();
    vectors++;
    if ({state, RegWrite} !== {4'd0, 1'b0}) begin
      miscompares++; $display("FAIL rtype_refetch: got %b expected %b", {state, RegWrite}, {4'd0, 1'b0});
    end
    opcode = 6'b001000;
    tick(); tick();
    vectors++;
    if ({state, ALUSrcA, ALUSrcB, RegWrite} !== {4'd9, 1'b1, 2'b10, 1'b0}) begin
      miscompares++; $display("FAIL addi_ex: got %b expected %b", {state, ALUSrcA, ALUSrcB, RegWrite}, {4'd9, 4'b1100});
    end
    tick();
    vectors++;
    if ({state, RegDst, RegWrite, MemToReg} !== {4'd10, 3'b010}) begin
      miscompares++; $display("FAIL addi_wb: got %b expected %b", {state, RegDst, RegWrite, MemToReg}, {4'd10, 3'b010});
    end
    tick();
    vectors++;
    if ({state, RegWrite} !== {4'd0, 1'b0} || r_wr_count !== w0 + 2) begin
      miscompares++; $display("FAIL b2b_writes: got state=%0d writes=%0d expected state=0 writes=2", state, r_wr_count - w0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; opcode = '0; alu_zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_beq(1'b1, 32'd8);
    test_beq(1'b0, 32'd5);
    test_lw_wait();
    test_sw_timeout(1'b0);
    test_sw_timeout(1'b1);
    test_opcode();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
